// File: rtl/alu_seq.sv
// Registered WIDTH-generic ALU with valid/ready handshakes, a multi-cycle
// shift-add multiplier (MUL/MULH) and an internal accumulator (ACC).
`timescale 1ns/1ps

module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       instruction,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,  OP_ROL  = 4'd9,  OP_SLT  = 4'd10, OP_SLTU = 4'd11,
        OP_MUL  = 4'd12, OP_MULH = 4'd13, OP_PASS = 4'd14, OP_ACC  = 4'd15
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    op_e op;
    assign op = op_e'(instruction);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     f_q, f_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 neg_q, neg_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic                 mulh_q, mulh_d;

    logic [SHW-1:0]       shamt;
    logic [SHW:0]         rol_rsh;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [WIDTH:0]       acc_ext;
    logic [2*WIDTH-1:0]   prod_step;

    assign shamt     = B[SHW-1:0];
    assign rol_rsh   = (SHW+1)'(WIDTH) - {1'b0, shamt};
    assign sum_ext   = {1'b0, A} + {1'b0, B};
    assign diff_ext  = {1'b0, A} - {1'b0, B};
    assign acc_ext   = {1'b0, acc_q} + {1'b0, A};
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign F         = f_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;

    // Single-cycle result for every opcode except MUL/MULH.
    logic [WIDTH-1:0] alu_f;
    logic             alu_c;
    logic             alu_v;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_f = sum_ext[WIDTH-1:0];
                alu_c = sum_ext[WIDTH];
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_f = diff_ext[WIDTH-1:0];
                alu_c = ~diff_ext[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_f = A & B;
            OP_OR:   alu_f = A | B;
            OP_XOR:  alu_f = A ^ B;
            OP_NOT:  alu_f = ~A;
            OP_SLL:  alu_f = A << shamt;
            OP_SRL:  alu_f = A >> shamt;
            OP_SRA:  alu_f = $signed(A) >>> shamt;
            OP_ROL:  alu_f = (A << shamt) | (A >> rol_rsh);
            OP_SLT:  alu_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_f = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_PASS: alu_f = B;
            OP_ACC: begin
                alu_f = acc_ext[WIDTH-1:0];
                alu_c = acc_ext[WIDTH];
                alu_v = (acc_q[WIDTH-1] == A[WIDTH-1]) && (acc_ext[WIDTH-1] != A[WIDTH-1]);
            end
            default: alu_f = '0;
        endcase
    end

    logic             load_res;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q && !out_ready;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        mulh_d      = mulh_q;
        load_res    = 1'b0;
        res         = '0;
        res_c       = 1'b0;
        res_v       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    if (op == OP_MUL || op == OP_MULH) begin
                        mcand_d     = {{WIDTH{1'b0}}, A};
                        mplier_d    = B;
                        prod_d      = '0;
                        cnt_d       = SHW'(WIDTH - 1);
                        mulh_d      = (op == OP_MULH);
                        out_valid_d = 1'b0;
                        state_d     = S_BUSY;
                    end else begin
                        load_res = 1'b1;
                        res      = alu_f;
                        res_c    = alu_c;
                        res_v    = alu_v;
                        if (op == OP_ACC) begin
                            acc_d = alu_f;
                        end
                    end
                end
            end
            S_BUSY: begin
                // One multiplier bit per edge, LSB first; the last step finishes the product.
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    load_res = 1'b1;
                    res      = mulh_q ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_res) begin
            f_d         = res;
            carry_d     = res_c;
            ovf_d       = res_v;
            zero_d      = (res == '0);
            neg_d       = res[WIDTH-1];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            f_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            mulh_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            f_q         <= f_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            mulh_q      <= mulh_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed steps plus random ops against an
// arithmetic reference model, on an 8-bit and a 16-bit instance.
`timescale 1ns/1ps

module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, or8, z8, c8, v8, n8;
    logic [3:0]  ins8;
    logic [7:0]  a8, b8, f8;
    logic        iv16, ir16, ov16, or16, z16, c16, v16, n16;
    logic [3:0]  ins16;
    logic [15:0] a16, b16, f16;

    int     checks = 0;
    int     errors = 0;
    longint acc8 = 0;
    longint acc16 = 0;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .instruction(ins8), .A(a8), .B(b8), .out_valid(ov8), .out_ready(or8),
        .F(f8), .zero(z8), .carry(c8), .overflow(v8), .negative(n8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .instruction(ins16), .A(a16), .B(b16), .out_valid(ov16), .out_ready(or16),
        .F(f16), .zero(z16), .carry(c16), .overflow(v16), .negative(n16)
    );

    typedef struct {
        logic [31:0] f;
        logic        z, c, v, n;
    } res_t;

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic res_t model(int w, int op, longint a, longint b, longint acc);
        res_t   r;
        longint m, half, sa, sb, sacc, t, s, fv;
        int     sh;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        sacc = (acc >= half) ? acc - m : acc;
        sh   = int'(b % longint'(w));
        fv   = 0;
        r.c  = 1'b0;
        r.v  = 1'b0;
        case (op)
            0: begin
                t = a + b; fv = t % m; r.c = (t >= m);
                s = sa + sb; r.v = (s < -half) || (s >= half);
            end
            1: begin
                t = a - b; fv = (t + m) % m; r.c = (a >= b);
                s = sa - sb; r.v = (s < -half) || (s >= half);
            end
            2:  fv = a & b;
            3:  fv = a | b;
            4:  fv = a ^ b;
            5:  fv = m - 1 - a;
            6:  fv = (a << sh) % m;
            7:  fv = a >> sh;
            8:  fv = ((sa >>> sh) + m) % m;
            9:  fv = ((a << sh) | (a >> (w - sh))) % m;
            10: fv = (sa < sb) ? 1 : 0;
            11: fv = (a < b) ? 1 : 0;
            12: fv = (a * b) % m;
            13: fv = (a * b) / m;
            14: fv = b;
            15: begin
                t = acc + a; fv = t % m; r.c = (t >= m);
                s = sacc + sa; r.v = (s < -half) || (s >= half);
            end
            default: fv = 0;
        endcase
        r.f = 32'(fv);
        r.z = (fv == 0);
        r.n = (fv >= half);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        acc8  = 0;
        acc16 = 0;
    endtask

    // Issue one op on the 8-bit DUT (must be able to accept), wait for its result, check it.
    task automatic op8(input int op, input logic [7:0] a, input logic [7:0] b, input bit poke);
        res_t e;
        int   n;
        bit   is_mul;
        is_mul = (op == 12 || op == 13);
        ins8 = 4'(op); a8 = a; b8 = b; iv8 = 1'b1;
        #1;
        chk($sformatf("op%0d in_ready idle", op), 32'(ir8), 32'd1);
        e = model(8, op, longint'(a), longint'(b), acc8);
        @(posedge clk); #1;
        iv8 = 1'b0;
        if (op == 15) acc8 = longint'(e.f);
        n = 0;
        while (ov8 !== 1'b1 && n < 40) begin
            chk($sformatf("op%0d in_ready busy", op), 32'(ir8), 32'd0);
            if (poke) begin
                iv8  = 1'($urandom_range(0, 1));
                ins8 = 4'($urandom);
                a8   = 8'($urandom);
                b8   = 8'($urandom);
            end
            @(posedge clk); #1;
            iv8 = 1'b0;
            n++;
        end
        chk($sformatf("op%0d latency", op), 32'(n), is_mul ? 32'd8 : 32'd0);
        chk($sformatf("op%0d out_valid", op), 32'(ov8), 32'd1);
        chk($sformatf("op%0d A=%0h B=%0h F", op, a, b), 32'(f8), e.f);
        chk($sformatf("op%0d zero", op), 32'(z8), 32'(e.z));
        chk($sformatf("op%0d carry", op), 32'(c8), 32'(e.c));
        chk($sformatf("op%0d overflow", op), 32'(v8), 32'(e.v));
        chk($sformatf("op%0d negative", op), 32'(n8), 32'(e.n));
    endtask

    task automatic op16(input int op, input logic [15:0] a, input logic [15:0] b);
        res_t e;
        int   n;
        ins16 = 4'(op); a16 = a; b16 = b; iv16 = 1'b1;
        #1;
        chk($sformatf("w16 op%0d in_ready idle", op), 32'(ir16), 32'd1);
        e = model(16, op, longint'(a), longint'(b), acc16);
        @(posedge clk); #1;
        iv16 = 1'b0;
        if (op == 15) acc16 = longint'(e.f);
        n = 0;
        while (ov16 !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("w16 op%0d latency", op), 32'(n), (op == 12 || op == 13) ? 32'd16 : 32'd0);
        chk($sformatf("w16 op%0d A=%0h B=%0h F", op, a, b), 32'(f16), e.f);
        chk($sformatf("w16 op%0d carry", op), 32'(c16), 32'(e.c));
        chk($sformatf("w16 op%0d overflow", op), 32'(v16), 32'(e.v));
        chk($sformatf("w16 op%0d zero", op), 32'(z16), 32'(e.z));
        chk($sformatf("w16 op%0d negative", op), 32'(n16), 32'(e.n));
    endtask

    initial begin
        iv8 = 1'b0; ins8 = '0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv16 = 1'b0; ins16 = '0; a16 = '0; b16 = '0; or16 = 1'b1;

        // Reset state
        #12;
        chk("rst F", 32'(f8), 32'd0);
        chk("rst out_valid", 32'(ov8), 32'd0);
        chk("rst in_ready", 32'(ir8), 32'd1);
        chk("rst flags", 32'({z8, c8, v8, n8}), 32'd0);
        chk("rst w16 F", 32'(f16), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Arithmetic / logic directed cases
        op8(0, 8'hFF, 8'h01, 0);
        chk("add ff+01 F", 32'(f8), 32'h00);
        chk("add ff+01 carry", 32'(c8), 32'd1);
        op8(1, 8'h80, 8'h01, 0);
        chk("sub 80-01 F", 32'(f8), 32'h7F);
        chk("sub 80-01 overflow", 32'(v8), 32'd1);
        op8(8, 8'h90, 8'h03, 0);
        chk("sra F", 32'(f8), 32'hF2);
        op8(9, 8'h81, 8'h09, 0);
        chk("rol F", 32'(f8), 32'h03);
        op8(10, 8'hFF, 8'h01, 0);
        chk("slt F", 32'(f8), 32'h01);
        op8(11, 8'hFF, 8'h01, 0);
        chk("sltu F", 32'(f8), 32'h00);

        // Multiplier, with stray in_valid pulses while busy
        op8(12, 8'h0F, 8'h11, 1);
        chk("mul 0f*11 F", 32'(f8), 32'hFF);
        op8(13, 8'hFF, 8'hFF, 1);
        chk("mulh ff*ff F", 32'(f8), 32'hFE);
        op8(12, 8'hFF, 8'hFF, 0);
        chk("mul ff*ff F", 32'(f8), 32'h01);

        // Backpressure: result held, then same-edge drain and accept
        op8(0, 8'h03, 8'h04, 0);
        or8 = 1'b0;
        ins8 = 4'd4; a8 = 8'h0F; b8 = 8'hFF; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp F held", 32'(f8), 32'h07);
            chk("bp out_valid held", 32'(ov8), 32'd1);
            chk("bp in_ready", 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        #1;
        chk("bp in_ready on drain", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("bp xor F", 32'(f8), 32'hF0);
        chk("bp xor out_valid", 32'(ov8), 32'd1);
        chk("bp xor negative", 32'(n8), 32'd1);

        // Accumulator
        do_reset();
        op8(15, 8'h10, 8'h00, 0);
        chk("acc1 F", 32'(f8), 32'h10);
        op8(15, 8'h20, 8'h00, 0);
        chk("acc2 F", 32'(f8), 32'h30);
        op8(15, 8'hF0, 8'h00, 0);
        chk("acc3 F", 32'(f8), 32'h20);
        chk("acc3 carry", 32'(c8), 32'd1);
        do_reset();
        op8(15, 8'h05, 8'h00, 0);
        chk("acc after reset F", 32'(f8), 32'h05);

        // Reset in the middle of a multiply
        op8(0, 8'h12, 8'h34, 0);
        ins8 = 4'd12; a8 = 8'h37; b8 = 8'h5A; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid-mul rst out_valid", 32'(ov8), 32'd0);
        chk("mid-mul rst F", 32'(f8), 32'd0);
        chk("mid-mul rst in_ready", 32'(ir8), 32'd1);
        rst_n = 1'b1;
        acc8 = 0; acc16 = 0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("aborted mul stays silent", 32'(ov8), 32'd0);
        op8(0, 8'h01, 8'h01, 0);
        chk("add after abort F", 32'(f8), 32'h02);

        // Random ops against the model
        for (int i = 0; i < 200; i++) begin
            op8(int'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1);
        end

        // 16-bit regression
        op16(0, 16'hFFFF, 16'h0001);
        chk("w16 add F", 32'(f16), 32'h0000);
        chk("w16 add carry", 32'(c16), 32'd1);
        op16(12, 16'h0100, 16'h0100);
        chk("w16 mul F", 32'(f16), 32'h0000);
        op16(13, 16'h0100, 16'h0100);
        chk("w16 mulh F", 32'(f16), 32'h0001);
        for (int i = 0; i < 40; i++) begin
            op16(int'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
